// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared constants and helpers for the digit-serial adder:
//               FSM state encoding, step count and step-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Number of digit steps needed to cover the full operand width.
    // A non-positive digit size returns 1 so that elaboration can reach the
    // configuration check instead of dividing by zero.
    function automatic int calc_steps(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end
        return width / digit;
    endfunction

    // Step counter width: $clog2(steps), never narrower than one bit.
    function automatic int calc_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder
// Description : Combinational ripple of DIGIT full-adder cells. Also exposes
//               the carry entering the top cell so the parent can derive
//               signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_top
);

    // w_c[i] is the carry entering cell i; w_c[DIGIT] leaves the slice.
    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout  = w_c[DIGIT];
    assign o_c_top = w_c[DIGIT-1];

endmodule : digit_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial adder. Sums two WIDTH-bit operands plus a
//               carry-in, DIGIT bits per clock, LSB digit first, reusing a
//               single digit_adder slice. start/busy/done handshake.
//               Optional macro SERIAL_ADDER_OVERFLOW_EN enables the signed
//               overflow output; otherwise o_overflow is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out,
    output logic             o_overflow
);

    localparam int                 c_STEPS = calc_steps(WIDTH, DIGIT);
    localparam int                 c_CNT_W = calc_cnt_w(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_STEPS - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH exactly");
    end

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic               w_c_top;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_dsum),
        .o_cout  (w_dcout),
        .o_c_top (w_c_top)
    );

    // New digits enter at the top so that after STEPS shifts the first
    // (least significant) digit has arrived at bit 0.
    if (DIGIT == WIDTH) begin : g_one_step
        assign w_acc_next = w_dsum;
    end else begin : g_multi_step
        assign w_acc_next = {w_dsum, r_acc[WIDTH-1:DIGIT]};
    end

    assign w_last = (r_cnt == c_LAST);

    // Control FSM, operand/sum shift registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_dcout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB cell differs from carry out of it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == c_RUN && w_last) begin
            r_ovf <= w_c_top ^ w_dcout;
        end
    end

    assign o_overflow = r_ovf;
`else
    logic w_unused_c_top;

    assign w_unused_c_top = w_c_top;
    assign o_overflow     = 1'b0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_sum       = r_sum;
    assign o_carry_out = r_cout;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder. Two instances: WIDTH=8,
//               DIGIT=1 (directed + random ops) and WIDTH=4, DIGIT=2
//               (all 512 operand combinations, back-to-back).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int s;
        int co;
        int ov;
        int due;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;
    int   last4 = -1;

    // 8-bit instance signals
    logic       rst8, start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    // 4-bit instance signals
    logic       rst4, start4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, co4, ov4;
    logic [3:0] sum4;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk         (clk),
        .rst         (rst8),
        .i_start     (start8),
        .i_a         (a8),
        .i_b         (b8),
        .i_cin       (cin8),
        .o_busy      (busy8),
        .o_done      (done8),
        .o_sum       (sum8),
        .o_carry_out (co8),
        .o_overflow  (ov8)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4 (
        .clk         (clk),
        .rst         (rst4),
        .i_start     (start4),
        .i_a         (a4),
        .i_b         (b4),
        .i_cin       (cin4),
        .o_busy      (busy4),
        .o_done      (done4),
        .o_sum       (sum4),
        .o_carry_out (co4),
        .o_overflow  (ov4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input int w, input int a, input int b, input int c, input int due);
        exp_t e;
        int   modv;
        int   half;
        int   full;
        int   sa;
        int   sb;
        int   t;
        modv  = 1 << w;
        half  = 1 << (w - 1);
        full  = a + b + c;
        e.s   = full % modv;
        e.co  = full / modv;
        sa    = (a >= half) ? a - modv : a;
        sb    = (b >= half) ? b - modv : b;
        t     = sa + sb + c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        e.ov  = (t > half - 1 || t < -half) ? 1 : 0;
`else
        e.ov  = (t == t) ? 0 : 0;
`endif
        e.due = due;
        return e;
    endfunction

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            chk("busy_done8", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                chk("spurious_done8", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                chk("sum8",  {24'd0, sum8}, e8.s);
                chk("cout8", {31'd0, co8},  e8.co);
                chk("ovf8",  {31'd0, ov8},  e8.ov);
                chk("lat8",  cyc,           e8.due);
            end
        end
    end

    // Monitor for the 4-bit instance, including result spacing
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            chk("busy_done4", {31'd0, busy4}, 32'd0);
            if (q4.size() == 0) begin
                chk("spurious_done4", 32'd1, 32'd0);
            end else begin
                e4 = q4.pop_front();
                chk("sum4",  {28'd0, sum4}, e4.s);
                chk("cout4", {31'd0, co4},  e4.co);
                chk("ovf4",  {31'd0, ov4},  e4.ov);
                chk("lat4",  cyc,           e4.due);
            end
            if (last4 >= 0) begin
                chk("interval4", cyc - last4, 32'd3);
            end
            last4 = cyc;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
        int guard;
        guard = 0;
        while (busy8 !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("accept_timeout8", 32'd1, 32'd0);
        a8     = a;
        b8     = b;
        cin8   = c;
        start8 = 1'b1;
        if (push) q8.push_back(model(8, int'(a), int'(b), int'(c), cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_sum8",  {24'd0, sum8},  32'd0);
        chk("rst_cout8", {31'd0, co8},   32'd0);
        chk("rst_ovf8",  {31'd0, ov8},   32'd0);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_sum4",  {28'd0, sum4},  32'd0);

        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);

        // Directed cases
        issue8(8'h0F, 8'h01, 1'b0, 1'b1);
        issue8(8'hFF, 8'h01, 1'b0, 1'b1);
        issue8(8'h7F, 8'h00, 1'b1, 1'b1);

        // start pulsed mid-RUN must be ignored
        issue8(8'h10, 8'h20, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (10) @(negedge clk);
        chk("held_sum8", {24'd0, sum8}, 32'h30);

        // Reset on the third RUN cycle aborts without a done pulse
        issue8(8'h55, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        chk("abort_busy8", {31'd0, busy8}, 32'd0);
        chk("abort_done8", {31'd0, done8}, 32'd0);
        chk("abort_sum8",  {24'd0, sum8},  32'd0);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        issue8(8'h01, 8'h02, 1'b0, 1'b1);

        // Random operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Exhaustive 4-bit run, start held through DONE
        start4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            g = 0;
            while (busy4 !== 1'b0 && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g >= 20) chk("accept_timeout4", 32'd1, 32'd0);
            a4   = 4'(i & 15);
            b4   = 4'((i >> 4) & 15);
            cin4 = 1'((i >> 8) & 1);
            q4.push_back(model(4, i & 15, (i >> 4) & 15, (i >> 8) & 1, cyc + 1 + 2));
            @(negedge clk);
        end
        start4 = 1'b0;

        // Drain outstanding results
        g = 0;
        while ((q8.size() > 0 || q4.size() > 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (q8.size() > 0) chk("drain8", q8.size(), 32'd0);
        if (q4.size() > 0) chk("drain4", q4.size(), 32'd0);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
